// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite register slave.
package axil_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

endpackage

// File: rtl/axil_reg_bank.sv
// Register array with byte-enable write port, combinational read mux and flat export.
module axil_reg_bank
  import axil_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [STRB_W-1:0]          wstrb,
  input  logic [IDX_W-1:0]           rd_idx,
  output logic [DATA_W-1:0]          rd_data,
  output logic [NUM_REGS*DATA_W-1:0] reg_q
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we) begin
      for (int k = 0; k < STRB_W; k++)
        if (wstrb[k]) regs[wr_idx][8*k +: 8] <= wdata[8*k +: 8];
    end
  end

  assign rd_data = regs[rd_idx];

  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_q[DATA_W*i +: DATA_W] = regs[i];
  end

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave register file with independent write and read FSMs.
// Define AXIL_ADDR_CHECK_EN to reject out-of-range accesses with SLVERR instead of aliasing.
module axil_reg_slave
  import axil_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       AWVALID,
  output logic                       AWREADY,
  input  logic [ADDR_W-1:0]          AWADDR,
  input  logic [2:0]                 AWPROT,
  input  logic                       WVALID,
  output logic                       WREADY,
  input  logic [DATA_W-1:0]          WDATA,
  input  logic [STRB_W-1:0]          WSTRB,
  output logic                       BVALID,
  input  logic                       BREADY,
  output logic [1:0]                 BRESP,
  input  logic                       ARVALID,
  output logic                       ARREADY,
  input  logic [ADDR_W-1:0]          ARADDR,
  input  logic [2:0]                 ARPROT,
  output logic                       RVALID,
  input  logic                       RREADY,
  output logic [DATA_W-1:0]          RDATA,
  output logic [1:0]                 RRESP,
  output logic [NUM_REGS*DATA_W-1:0] reg_q
);

  localparam int IDX_W = $clog2(NUM_REGS);

  wr_state_t         w_state;
  rd_state_t         r_state;
  logic              aw_held, w_held;
  logic [IDX_W-1:0]  aw_idx_q;
  logic [DATA_W-1:0] w_data_q;
  logic [STRB_W-1:0] w_strb_q;

  logic              aw_hs, w_hs, commit, bank_we;
  logic [IDX_W-1:0]  wr_idx, ar_idx;
  logic [DATA_W-1:0] wr_data, rd_data;
  logic [STRB_W-1:0] wr_strb;

  wire unused_inputs = &{1'b0, AWPROT, ARPROT, AWADDR, ARADDR};

  assign AWREADY = (w_state == W_IDLE) && !aw_held;
  assign WREADY  = (w_state == W_IDLE) && !w_held;
  assign ARREADY = (r_state == R_IDLE);

  assign aw_hs  = AWVALID && AWREADY;
  assign w_hs   = WVALID && WREADY;
  assign commit = (w_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);

  // Held values take priority; otherwise the beat handshaking this edge is used directly.
  assign wr_idx  = aw_held ? aw_idx_q : AWADDR[IDX_W+1:2];
  assign wr_data = w_held  ? w_data_q : WDATA;
  assign wr_strb = w_held  ? w_strb_q : WSTRB;
  assign ar_idx  = ARADDR[IDX_W+1:2];

`ifdef AXIL_ADDR_CHECK_EN
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NUM_REGS*4);
  logic aw_oor_q, wr_oor, ar_oor;
  assign wr_oor  = aw_held ? aw_oor_q : (AWADDR >= ADDR_LIMIT);
  assign ar_oor  = (ARADDR >= ADDR_LIMIT);
  assign bank_we = commit && !wr_oor;
`else
  assign bank_we = commit;
`endif

  axil_reg_bank #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_bank (
    .clk     (clk),
    .rst     (rst),
    .we      (bank_we),
    .wr_idx  (wr_idx),
    .wdata   (wr_data),
    .wstrb   (wr_strb),
    .rd_idx  (ar_idx),
    .rd_data (rd_data),
    .reg_q   (reg_q)
  );

  // Write channel: collect AW and W in either order, commit once both are present.
  always_ff @(posedge clk) begin
    if (!rst) begin
      w_state  <= W_IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      BVALID   <= 1'b0;
      BRESP    <= RESP_OKAY;
`ifdef AXIL_ADDR_CHECK_EN
      aw_oor_q <= 1'b0;
`endif
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_held  <= 1'b1;
            aw_idx_q <= AWADDR[IDX_W+1:2];
`ifdef AXIL_ADDR_CHECK_EN
            aw_oor_q <= (AWADDR >= ADDR_LIMIT);
`endif
          end
          if (w_hs) begin
            w_held   <= 1'b1;
            w_data_q <= WDATA;
            w_strb_q <= WSTRB;
          end
          if (commit) begin
            w_state <= W_RESP;
            BVALID  <= 1'b1;
`ifdef AXIL_ADDR_CHECK_EN
            BRESP   <= wr_oor ? RESP_SLVERR : RESP_OKAY;
`else
            BRESP   <= RESP_OKAY;
`endif
          end
        end
        W_RESP: begin
          if (BREADY) begin
            w_state <= W_IDLE;
            BVALID  <= 1'b0;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read channel: sample the bank on the AR handshake, hold until RREADY.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= R_IDLE;
      RVALID  <= 1'b0;
      RDATA   <= '0;
      RRESP   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ARVALID) begin
            r_state <= R_DATA;
            RVALID  <= 1'b1;
`ifdef AXIL_ADDR_CHECK_EN
            RDATA   <= ar_oor ? '0 : rd_data;
            RRESP   <= ar_oor ? RESP_SLVERR : RESP_OKAY;
`else
            RDATA   <= rd_data;
            RRESP   <= RESP_OKAY;
`endif
          end
        end
        R_DATA: begin
          if (RREADY) begin
            r_state <= R_IDLE;
            RVALID  <= 1'b0;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule
